// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Stores a pattern of up to MAX_LEN bits and shifts it out LSB first on a
//   registered serial line. The stored pattern and length stay in place after a
//   transmission, so a later start without a load replays the same sequence.
//
//   State   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting; load captures pattern/len, start begins a transfer
//   SHIFT   | one stored bit is on a each cycle, busy high
//   DONE    | a=0, busy=0, done high for this single cycle
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   capture pattern/len (honoured only in IDLE)
//   pattern  in   MAX_LEN bits, transmitted LSB first
//   len      in   bit count; values above MAX_LEN are clamped
//   start    in   begin transmission (honoured only in IDLE)
//   repeat_i in   only with SERIAL_PATTERN_TX_REPEAT_EN: loop the pattern
//   a        out  registered serial bit stream
//   busy     out  high while bits are being driven
//   done     out  one-cycle pulse after the last bit
//   err      out  one-cycle pulse on start with an effective length of 0
//
// Build option
//   SERIAL_PATTERN_TX_REPEAT_EN adds repeat_i (after start). When high at the
//   edge that ends the last bit, the pattern restarts from bit 0 with no DONE
//   cycle. The port is not called "repeat" because that is a reserved word.

module serial_pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               start,
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    input  logic               repeat_i,
`endif
    output logic               a,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    // Working copy that is shifted out, so pat_q survives for replay.
    logic [MAX_LEN-1:0] sh_q;
    // Bits still to send after the one currently on a; stops at 0, never wraps.
    logic [LEN_W-1:0]   cnt_q;

    logic [LEN_W-1:0]   len_clamp_d;
    logic [LEN_W-1:0]   eff_len_d;
    logic [MAX_LEN-1:0] eff_pat_d;

    // A load in the same cycle as start transmits the freshly presented data.
    always_comb begin
        len_clamp_d = (len > MAX_LEN_L) ? MAX_LEN_L : len;
        eff_len_d   = load ? len_clamp_d : len_q;
        eff_pat_d   = load ? pattern : pat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            a       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        pat_q <= pattern;
                        len_q <= len_clamp_d;
                    end
                    if (start) begin
                        if (eff_len_d == '0) begin
                            err <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                            a       <= eff_pat_d[0];
                            busy    <= 1'b1;
                            sh_q    <= eff_pat_d >> 1;
                            cnt_q   <= eff_len_d - 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
                        if (repeat_i) begin
                            a     <= pat_q[0];
                            sh_q  <= pat_q >> 1;
                            cnt_q <= len_q - 1'b1;
                        end else begin
                            state_q <= DONE;
                            a       <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
`else
                        state_q <= DONE;
                        a       <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        a     <= sh_q[0];
                        sh_q  <= sh_q >> 1;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    a       <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx (default build, 16-bit pattern).
module tb_serial_pattern_tx;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] pattern;
    logic [4:0]  len;
    logic        start;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
    logic        repeat_i;
`endif
    logic        a;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int failures;

    serial_pattern_tx #(.MAX_LEN(16), .LEN_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .pattern (pattern),
        .len     (len),
        .start   (start),
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        .repeat_i(repeat_i),
`endif
        .a       (a),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives start (with whatever load/pattern/len the caller left set) and
    // checks the L-bit stream, the done cycle, and the return to idle.
    // disturb_at >= 0 pulses start+load with junk while bit disturb_at is out.
    // poke_done pulses start during the done cycle, which must be ignored.
    task automatic run(input string tag, input logic [31:0] bits, input int L,
                       input int disturb_at, input bit poke_done);
        start = 1'b1;
        for (int i = 0; i < L; i++) begin
            step();
            start = 1'b0;
            load  = 1'b0;
            check({tag, "_a"}, 32'(a), 32'(bits[i]));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            if (i == disturb_at) begin
                start   = 1'b1;
                load    = 1'b1;
                pattern = 16'hFFFF;
                len     = 5'd2;
            end
        end
        step();
        start = 1'b0;
        load  = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_a"}, 32'(a), 32'd0);
        if (poke_done) start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_done_end"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_a"}, 32'(a), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        pattern  = 16'h0000;
        len      = 5'd0;
        start    = 1'b0;
`ifdef SERIAL_PATTERN_TX_REPEAT_EN
        repeat_i = 1'b0;
`endif
        #1;
        check("rst_a", 32'(a), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic transfer: 0xE, length 4 -> 0,1,1,1
        load = 1'b1; pattern = 16'h000E; len = 5'd4;
        step();
        load = 1'b0;
        run("basic", 32'h0000_000E, 4, -1, 1'b1);

        // Zero length gives a single err pulse and no activity
        load = 1'b1; pattern = 16'h1234; len = 5'd0;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("zero_err", 32'(err), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_a", 32'(a), 32'd0);
        step();
        check("zero_err_end", 32'(err), 32'd0);
        check("zero_busy2", 32'(busy), 32'd0);

        // Same-cycle load+start uses the new data over stored 0xFFFF
        load = 1'b1; pattern = 16'hFFFF; len = 5'd16;
        step();
        load = 1'b1; pattern = 16'h0005; len = 5'd3;
        run("ldst", 32'h0000_0005, 3, -1, 1'b0);

        // Length above MAX_LEN is clamped to exactly 16 bits
        load = 1'b1; pattern = 16'hA5C3; len = 5'd31;
        step();
        load = 1'b0;
        run("clamp", 32'h0000_A5C3, 16, -1, 1'b0);

        // start/load during SHIFT ignored; replay gives the original byte
        load = 1'b1; pattern = 16'h00B4; len = 5'd8;
        step();
        load = 1'b0;
        run("busyld", 32'h0000_00B4, 8, 3, 1'b0);
        run("replay", 32'h0000_00B4, 8, -1, 1'b0);

        // Reset in the middle of a length-6 transfer
        load = 1'b1; pattern = 16'h002D; len = 5'd6;
        step();
        load = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid_bit2", 32'(a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", 32'(a), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        step();
        check("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_rst_err", 32'(err), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_a", 32'(a), 32'd0);
        step();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
